// File: rtl/mcd_dram_axi_arbiter.sv
// 2:1 AXI4 arbiter sharing the DRAM master port between the memcached hash-table (S0)
// and value-store (S1) masters; responses return by the source tag in the ID MSB.
module mcd_dram_axi_arbiter #(
    parameter int ADDR_WID  = 32,
    parameter int DATA_WID  = 512,
    parameter int ID_WID    = 5,
    parameter int MAX_OUTST = 8
) (
    input  logic                  mem_clk,
    input  logic                  mem_resetn,
    input  logic [ADDR_WID-1:0]   s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    input  logic [3:0]            s0_arcache,
    input  logic [2:0]            s0_arprot,
    input  logic [ID_WID-1:0]     s0_arid,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WID-1:0]   s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    input  logic [ADDR_WID-1:0]   s0_awaddr,
    input  logic [7:0]            s0_awlen,
    input  logic [2:0]            s0_awsize,
    input  logic [1:0]            s0_awburst,
    input  logic [3:0]            s0_awcache,
    input  logic [2:0]            s0_awprot,
    input  logic [ID_WID-1:0]     s0_awid,
    input  logic                  s0_awvalid,
    output logic                  s0_awready,
    input  logic [DATA_WID-1:0]   s0_wdata,
    input  logic [DATA_WID/8-1:0] s0_wstrb,
    input  logic                  s0_wlast,
    input  logic                  s0_wvalid,
    output logic                  s0_wready,
    output logic [1:0]            s0_bresp,
    output logic                  s0_bvalid,
    input  logic                  s0_bready,
    input  logic [ADDR_WID-1:0]   s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    input  logic [3:0]            s1_arcache,
    input  logic [2:0]            s1_arprot,
    input  logic [ID_WID-1:0]     s1_arid,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WID-1:0]   s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    input  logic [ADDR_WID-1:0]   s1_awaddr,
    input  logic [7:0]            s1_awlen,
    input  logic [2:0]            s1_awsize,
    input  logic [1:0]            s1_awburst,
    input  logic [3:0]            s1_awcache,
    input  logic [2:0]            s1_awprot,
    input  logic [ID_WID-1:0]     s1_awid,
    input  logic                  s1_awvalid,
    output logic                  s1_awready,
    input  logic [DATA_WID-1:0]   s1_wdata,
    input  logic [DATA_WID/8-1:0] s1_wstrb,
    input  logic                  s1_wlast,
    input  logic                  s1_wvalid,
    output logic                  s1_wready,
    output logic [1:0]            s1_bresp,
    output logic                  s1_bvalid,
    input  logic                  s1_bready,
    output logic [ADDR_WID-1:0]   m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arlock,
    output logic [3:0]            m_arcache,
    output logic [2:0]            m_arprot,
    output logic [3:0]            m_arqos,
    output logic [3:0]            m_arregion,
    output logic [ID_WID-1:0]     m_arid,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WID-1:0]   m_rdata,
    input  logic [ID_WID-1:0]     m_rid,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [ADDR_WID-1:0]   m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awlock,
    output logic [3:0]            m_awcache,
    output logic [2:0]            m_awprot,
    output logic [3:0]            m_awqos,
    output logic [3:0]            m_awregion,
    output logic [ID_WID-1:0]     m_awid,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WID-1:0]   m_wdata,
    output logic [DATA_WID/8-1:0] m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [ID_WID-1:0]     m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    localparam int CNT_WID = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_WID-1:0] CNT_MAX = CNT_WID'(MAX_OUTST);

    localparam logic [0:0] AR_IDLE  = 1'b0;
    localparam logic [0:0] AR_GRANT = 1'b1;
    localparam logic [1:0] AW_IDLE  = 2'd0;
    localparam logic [1:0] AW_ADDR  = 2'd1;
    localparam logic [1:0] AW_DATA  = 2'd2;

    logic [0:0]         ar_state;
    logic               ar_sel, last_ar, ar_pick, ar_hs, r_done;
    logic [1:0]         aw_state;
    logic               aw_sel, last_aw, aw_pick, aw_hs, w_hs, b_hs;
    logic [CNT_WID-1:0] rd_cnt, wr_cnt;
    logic               r_tgt, b_tgt;

    // When both masters request, the one not served last wins; a lone requester always wins.
    assign ar_pick = (s0_arvalid && s1_arvalid) ? ~last_ar : s1_arvalid;
    assign aw_pick = (s0_awvalid && s1_awvalid) ? ~last_aw : s1_awvalid;

    assign ar_hs  = m_arvalid && m_arready;
    assign r_done = m_rvalid && m_rready && m_rlast;
    assign aw_hs  = m_awvalid && m_awready;
    assign w_hs   = m_wvalid && m_wready;
    assign b_hs   = m_bvalid && m_bready;

    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) begin
            ar_state <= AR_IDLE;
            ar_sel   <= 1'b0;
            last_ar  <= 1'b1;
        end else begin
            case (ar_state)
                AR_IDLE: if ((s0_arvalid || s1_arvalid) && rd_cnt < CNT_MAX) begin
                    ar_sel   <= ar_pick;
                    ar_state <= AR_GRANT;
                end
                default: if (ar_hs) begin
                    last_ar  <= ar_sel;
                    ar_state <= AR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) begin
            aw_state <= AW_IDLE;
            aw_sel   <= 1'b0;
            last_aw  <= 1'b1;
        end else begin
            case (aw_state)
                AW_IDLE: if ((s0_awvalid || s1_awvalid) && wr_cnt < CNT_MAX) begin
                    aw_sel   <= aw_pick;
                    aw_state <= AW_ADDR;
                end
                AW_ADDR: if (aw_hs) begin
                    last_aw  <= aw_sel;
                    aw_state <= AW_DATA;
                end
                AW_DATA: if (w_hs && m_wlast) aw_state <= AW_IDLE;
                default: aw_state <= AW_IDLE;
            endcase
        end
    end

    // Response beats arriving with a zero count are still routed; the count just never underflows.
    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (ar_hs && !(r_done && rd_cnt != '0))
                rd_cnt <= rd_cnt + 1'b1;
            else if (!ar_hs && r_done && rd_cnt != '0)
                rd_cnt <= rd_cnt - 1'b1;
            if (aw_hs && !(b_hs && wr_cnt != '0))
                wr_cnt <= wr_cnt + 1'b1;
            else if (!aw_hs && b_hs && wr_cnt != '0)
                wr_cnt <= wr_cnt - 1'b1;
        end
    end

    assign m_arvalid  = (ar_state == AR_GRANT);
    assign m_araddr   = ar_sel ? s1_araddr  : s0_araddr;
    assign m_arlen    = ar_sel ? s1_arlen   : s0_arlen;
    assign m_arsize   = ar_sel ? s1_arsize  : s0_arsize;
    assign m_arburst  = ar_sel ? s1_arburst : s0_arburst;
    assign m_arcache  = ar_sel ? s1_arcache : s0_arcache;
    assign m_arprot   = ar_sel ? s1_arprot  : s0_arprot;
    assign m_arid     = {ar_sel, ar_sel ? s1_arid[ID_WID-2:0] : s0_arid[ID_WID-2:0]};
    assign m_arlock   = 1'b0;
    assign m_arqos    = 4'd0;
    assign m_arregion = 4'd0;
    assign s0_arready = m_arvalid && !ar_sel && m_arready;
    assign s1_arready = m_arvalid &&  ar_sel && m_arready;

    assign m_awvalid  = (aw_state == AW_ADDR);
    assign m_awaddr   = aw_sel ? s1_awaddr  : s0_awaddr;
    assign m_awlen    = aw_sel ? s1_awlen   : s0_awlen;
    assign m_awsize   = aw_sel ? s1_awsize  : s0_awsize;
    assign m_awburst  = aw_sel ? s1_awburst : s0_awburst;
    assign m_awcache  = aw_sel ? s1_awcache : s0_awcache;
    assign m_awprot   = aw_sel ? s1_awprot  : s0_awprot;
    assign m_awid     = {aw_sel, aw_sel ? s1_awid[ID_WID-2:0] : s0_awid[ID_WID-2:0]};
    assign m_awlock   = 1'b0;
    assign m_awqos    = 4'd0;
    assign m_awregion = 4'd0;
    assign s0_awready = m_awvalid && !aw_sel && m_awready;
    assign s1_awready = m_awvalid &&  aw_sel && m_awready;

    assign m_wvalid  = (aw_state == AW_DATA) && (aw_sel ? s1_wvalid : s0_wvalid);
    assign m_wdata   = aw_sel ? s1_wdata : s0_wdata;
    assign m_wstrb   = aw_sel ? s1_wstrb : s0_wstrb;
    assign m_wlast   = aw_sel ? s1_wlast : s0_wlast;
    assign s0_wready = (aw_state == AW_DATA) && !aw_sel && m_wready;
    assign s1_wready = (aw_state == AW_DATA) &&  aw_sel && m_wready;

    assign r_tgt     = m_rid[ID_WID-1];
    assign s0_rvalid = m_rvalid && !r_tgt;
    assign s1_rvalid = m_rvalid &&  r_tgt;
    assign m_rready  = r_tgt ? s1_rready : s0_rready;
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rresp  = m_rresp;
    assign s1_rresp  = m_rresp;
    assign s0_rlast  = m_rlast;
    assign s1_rlast  = m_rlast;

    assign b_tgt     = m_bid[ID_WID-1];
    assign s0_bvalid = m_bvalid && !b_tgt;
    assign s1_bvalid = m_bvalid &&  b_tgt;
    assign m_bready  = b_tgt ? s1_bready : s0_bready;
    assign s0_bresp  = m_bresp;
    assign s1_bresp  = m_bresp;

    logic unused_bits;
    assign unused_bits = ^{s0_arid[ID_WID-1], s1_arid[ID_WID-1], s0_awid[ID_WID-1],
                           s1_awid[ID_WID-1], m_rid[ID_WID-2:0], m_bid[ID_WID-2:0]};

endmodule

// File: tb/tb_mcd_dram_axi_arbiter.sv
// Directed self-checking bench for mcd_dram_axi_arbiter: inputs change 1 ns after the
// rising edge and outputs are checked 1 ns after that.
module tb_mcd_dram_axi_arbiter;

    localparam int AW = 32;
    localparam int DW = 512;
    localparam int IW = 5;

    logic mem_clk = 1'b0;
    logic mem_resetn;

    logic [AW-1:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, m_araddr, m_awaddr;
    logic [7:0] s0_arlen, s1_arlen, s0_awlen, s1_awlen, m_arlen, m_awlen;
    logic [2:0] s0_arsize, s1_arsize, s0_awsize, s1_awsize, m_arsize, m_awsize;
    logic [1:0] s0_arburst, s1_arburst, s0_awburst, s1_awburst, m_arburst, m_awburst;
    logic [3:0] s0_arcache, s1_arcache, s0_awcache, s1_awcache, m_arcache, m_awcache;
    logic [2:0] s0_arprot, s1_arprot, s0_awprot, s1_awprot, m_arprot, m_awprot;
    logic [IW-1:0] s0_arid, s1_arid, s0_awid, s1_awid, m_arid, m_awid, m_rid, m_bid;
    logic s0_arvalid, s1_arvalid, s0_arready, s1_arready, m_arvalid, m_arready;
    logic s0_awvalid, s1_awvalid, s0_awready, s1_awready, m_awvalid, m_awready;
    logic [DW-1:0] s0_rdata, s1_rdata, m_rdata, s0_wdata, s1_wdata, m_wdata;
    logic [DW/8-1:0] s0_wstrb, s1_wstrb, m_wstrb;
    logic [1:0] s0_rresp, s1_rresp, m_rresp, s0_bresp, s1_bresp, m_bresp;
    logic s0_rlast, s1_rlast, m_rlast, s0_rvalid, s1_rvalid, m_rvalid;
    logic s0_rready, s1_rready, m_rready;
    logic s0_wlast, s1_wlast, m_wlast, s0_wvalid, s1_wvalid, m_wvalid;
    logic s0_wready, s1_wready, m_wready;
    logic s0_bvalid, s1_bvalid, m_bvalid, s0_bready, s1_bready, m_bready;
    logic m_arlock, m_awlock;
    logic [3:0] m_arqos, m_awqos, m_arregion, m_awregion;

    int checks = 0;
    int errors = 0;

    always #5 mem_clk = ~mem_clk;

    mcd_dram_axi_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .ID_WID(IW), .MAX_OUTST(8)) dut (
        .mem_clk(mem_clk), .mem_resetn(mem_resetn),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
        .s0_arcache(s0_arcache), .s0_arprot(s0_arprot), .s0_arid(s0_arid), .s0_arvalid(s0_arvalid),
        .s0_arready(s0_arready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
        .s0_awcache(s0_awcache), .s0_awprot(s0_awprot), .s0_awid(s0_awid), .s0_awvalid(s0_awvalid),
        .s0_awready(s0_awready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
        .s0_bready(s0_bready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
        .s1_arcache(s1_arcache), .s1_arprot(s1_arprot), .s1_arid(s1_arid), .s1_arvalid(s1_arvalid),
        .s1_arready(s1_arready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
        .s1_awcache(s1_awcache), .s1_awprot(s1_awprot), .s1_awid(s1_awid), .s1_awvalid(s1_awvalid),
        .s1_awready(s1_awready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
        .s1_bready(s1_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
        .m_arregion(m_arregion), .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
        .m_awregion(m_awregion), .m_awid(m_awid), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        mem_resetn = 1'b0;
        applyStimulus(1);
        mem_resetn = 1'b1;
        applyStimulus(1);
    endtask

    initial begin
        int n0, n1, exp_sel;
        logic [IW-1:0] exp_id;

        mem_resetn = 1'b1;
        {s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arcache, s0_arprot, s0_arid, s0_arvalid} = '0;
        {s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arcache, s1_arprot, s1_arid, s1_arvalid} = '0;
        {s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awcache, s0_awprot, s0_awid, s0_awvalid} = '0;
        {s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awcache, s1_awprot, s1_awid, s1_awvalid} = '0;
        {s0_wdata, s0_wstrb, s0_wlast, s0_wvalid, s1_wdata, s1_wstrb, s1_wlast, s1_wvalid} = '0;
        {s0_rready, s1_rready, s0_bready, s1_bready} = '0;
        {m_arready, m_awready, m_wready} = '0;
        {m_rdata, m_rid, m_rresp, m_rlast, m_rvalid, m_bid, m_bresp, m_bvalid} = '0;
        #1 mem_resetn = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid}), 64'd0);
        checkOutput("rst_s_readies", 64'({s0_arready, s1_arready, s0_awready, s1_awready, s0_wready, s1_wready}), 64'd0);
        checkOutput("rst_s_resp_valids", 64'({s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid}), 64'd0);
        checkOutput("rst_counters", 64'({dut.rd_cnt, dut.wr_cnt}), 64'd0);
        checkOutput("const_lock_qos_region", 64'({m_arlock, m_awlock, m_arqos, m_awqos, m_arregion, m_awregion}), 64'd0);
        applyStimulus(2);
        mem_resetn = 1'b1;
        applyStimulus(1);

        $display("[TB] single S0 read");
        s0_araddr = 32'h100; s0_arlen = 8'd3; s0_arid = 5'h03; s0_arvalid = 1'b1; m_arready = 1'b1;
        #1 checkOutput("t1_bubble_arvalid", 64'(m_arvalid), 64'd0);
        applyStimulus(1);
        checkOutput("t1_arvalid", 64'(m_arvalid), 64'd1);
        checkOutput("t1_arid", 64'(m_arid), 64'h03);
        checkOutput("t1_araddr", 64'(m_araddr), 64'h100);
        checkOutput("t1_arlen", 64'(m_arlen), 64'd3);
        checkOutput("t1_readies", 64'({s0_arready, s1_arready}), 64'b10);
        applyStimulus(1);
        s0_arvalid = 1'b0;
        #1 checkOutput("t1_rd_cnt_one", 64'(dut.rd_cnt), 64'd1);
        s0_rready = 1'b1; s1_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1; m_rid = 5'h03; m_rlast = (k == 3);
            m_rdata = '0; m_rdata[63:0] = 64'h1000 + 64'(k);
            #1;
            checkOutput("t1_r_route", 64'({s0_rvalid, s1_rvalid, m_rready}), 64'b101);
            checkOutput("t1_rdata", s0_rdata[63:0], 64'h1000 + 64'(k));
            applyStimulus(1);
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 checkOutput("t1_rd_cnt_zero", 64'(dut.rd_cnt), 64'd0);

        $display("[TB] round robin reads");
        applyReset();
        n0 = 0; n1 = 0;
        s0_arid = 5'h00; s1_arid = 5'h00; s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            applyStimulus(1);
            exp_sel = g % 2;
            exp_id = (exp_sel == 1) ? (5'h10 | 5'(n1)) : 5'(n0);
            checkOutput($sformatf("t2_arid_g%0d", g), 64'(m_arid), 64'(exp_id));
            if (exp_sel == 1) checkOutput("t2_s0_blocked", 64'(s0_arready), 64'd0);
            else              checkOutput("t2_s1_blocked", 64'(s1_arready), 64'd0);
            applyStimulus(1);
            if (exp_sel == 0) begin
                n0++; s0_arid = 5'(n0);
                if (n0 == 4) s0_arvalid = 1'b0;
            end else begin
                n1++; s1_arid = 5'(n1);
                if (n1 == 4) s1_arvalid = 1'b0;
            end
        end
        #1 checkOutput("t2_rd_cnt_full", 64'(dut.rd_cnt), 64'd8);

        $display("[TB] outstanding read cap");
        s0_arid = 5'h05; s0_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("t3_capped_arvalid", 64'(m_arvalid), 64'd0);
        end
        s0_rready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h00;
        applyStimulus(1);
        m_rvalid = 1'b0;
        #1;
        checkOutput("t3_rd_cnt_after_rlast", 64'(dut.rd_cnt), 64'd7);
        checkOutput("t3_still_bubble", 64'(m_arvalid), 64'd0);
        applyStimulus(1);
        checkOutput("t3_regrant_arvalid", 64'(m_arvalid), 64'd1);
        checkOutput("t3_regrant_arid", 64'(m_arid), 64'h05);
        s1_rready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h10;
        applyStimulus(1);
        s0_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        #1 checkOutput("t3_rd_cnt_coincide", 64'(dut.rd_cnt), 64'd7);

        $display("[TB] S1 write with W locking");
        applyReset();
        s1_awaddr = 32'h200; s1_awlen = 8'd1; s1_awid = 5'h02; s1_awvalid = 1'b1;
        s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = '0; s0_wdata[63:0] = 64'hAAAA;
        s1_wvalid = 1'b1; s1_wlast = 1'b0; s1_wdata = '0; s1_wdata[63:0] = 64'hB0;
        m_awready = 1'b1; m_wready = 1'b1;
        #1 checkOutput("t4_idle_w", 64'({m_wvalid, s0_wready, s1_wready}), 64'd0);
        applyStimulus(1);
        checkOutput("t4_awvalid", 64'(m_awvalid), 64'd1);
        checkOutput("t4_awid", 64'(m_awid), 64'h12);
        checkOutput("t4_awready", 64'({s0_awready, s1_awready}), 64'b01);
        checkOutput("t4_addr_w_stall", 64'({m_wvalid, s0_wready}), 64'd0);
        applyStimulus(1);
        s1_awvalid = 1'b0;
        #1;
        checkOutput("t4_wr_cnt_one", 64'(dut.wr_cnt), 64'd1);
        checkOutput("t4_w_beat0", 64'({m_wvalid, s1_wready, s0_wready, m_wlast}), 64'b1100);
        checkOutput("t4_wdata0", m_wdata[63:0], 64'hB0);
        applyStimulus(1);
        s1_wdata[63:0] = 64'hB1; s1_wlast = 1'b1;
        #1;
        checkOutput("t4_wdata1", m_wdata[63:0], 64'hB1);
        checkOutput("t4_wlast1", 64'({m_wlast, s0_wready}), 64'b10);
        applyStimulus(1);
        s1_wvalid = 1'b0; s1_wlast = 1'b0;
        #1;
        checkOutput("t4_back_idle", 64'(dut.aw_state), 64'd0);
        checkOutput("t4_idle_s0_stalled", 64'({m_wvalid, s0_wready}), 64'd0);
        s0_wvalid = 1'b0; s0_wlast = 1'b0;
        m_bvalid = 1'b1; m_bid = 5'h10; s1_bready = 1'b1; s0_bready = 1'b0;
        #1 checkOutput("t4_b_route", 64'({s1_bvalid, s0_bvalid, m_bready}), 64'b101);
        applyStimulus(1);
        m_bvalid = 1'b0;
        #1 checkOutput("t4_wr_cnt_zero", 64'(dut.wr_cnt), 64'd0);

        $display("[TB] reset mid burst");
        s0_awaddr = 32'h300; s0_awlen = 8'd3; s0_awid = 5'h01; s0_awvalid = 1'b1;
        s0_wvalid = 1'b1; s0_wdata[63:0] = 64'hD0;
        applyStimulus(2);
        s0_awvalid = 1'b0;
        #1 checkOutput("t5_in_data", 64'({dut.aw_state, m_wvalid}), 64'b101);
        applyStimulus(1);
        mem_resetn = 1'b0;
        #1;
        checkOutput("t5_async_valids", 64'({m_awvalid, m_wvalid, s0_wready, s0_awready}), 64'd0);
        checkOutput("t5_async_state_cnt", 64'({dut.aw_state, dut.wr_cnt}), 64'd0);
        s0_wvalid = 1'b0;
        applyStimulus(1);
        mem_resetn = 1'b1;
        s1_awaddr = 32'h400; s1_awid = 5'h07; s1_awvalid = 1'b1;
        #1 checkOutput("t5_post_bubble", 64'(m_awvalid), 64'd0);
        applyStimulus(1);
        checkOutput("t5_post_awid", 64'(m_awid), 64'h17);
        checkOutput("t5_post_awready", 64'({s0_awready, s1_awready}), 64'b01);
        applyStimulus(1);
        s1_awvalid = 1'b0;

        $display("[TB] R backpressure to S1");
        s0_rready = 1'b1; s1_rready = 1'b0;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 5'h11; m_rdata = '0; m_rdata[63:0] = 64'hCAFE;
        #1 checkOutput("t6_blocked", 64'({m_rready, s1_rvalid, s0_rvalid}), 64'b010);
        applyStimulus(1);
        checkOutput("t6_held", 64'({m_rready, s1_rvalid, s0_rvalid}), 64'b010);
        checkOutput("t6_held_data", s1_rdata[63:0], 64'hCAFE);
        checkOutput("t6_rd_cnt", 64'(dut.rd_cnt), 64'd0);
        s1_rready = 1'b1;
        #1 checkOutput("t6_released", 64'(m_rready), 64'd1);
        applyStimulus(1);
        m_rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
